// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite compositor.
//   COORD_W      default coordinate width for row/col/sprite positions
//   TRANSPARENT  sprite colour key that lets the background show through
//   rgb12_t      4:4:4 colour word, red in [11:8], blue in [3:0]
//   tile_code_t  tile-map entry codes
//   sprite_t     one sprite slot: top-left position plus enable
//   tile_colour  background colour for a tile code
package vga_pkg;

  localparam int COORD_W = 11;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t TRANSPARENT = 12'hF0F;

  typedef enum logic [7:0] {
    BDR = 8'd0,
    GND = 8'd1,
    SKY = 8'd2,
    TKN = 8'd3,
    BLK = 8'd4,
    CK1 = 8'd5,
    CK2 = 8'd6
  } tile_code_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } sprite_t;

  // Unknown codes fall back to black, the same as the border tile.
  function automatic rgb12_t tile_colour(input logic [7:0] code);
    rgb12_t c;
    case (code)
      GND:      c = 12'h0F2;
      SKY, TKN: c = 12'h09F;
      BLK:      c = 12'h843;
      CK1:      c = 12'hAA3;
      CK2:      c = 12'h111;
      default:  c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sprite_bank.sv
// Double-buffered sprite position registers.
//   clk, reset        pixel clock, async active-high reset
//   frame_start       commits every shadow slot into the active set
//   wr_valid/wr_ready handshake for a single-slot update
//   wr_idx, wr_x, wr_y, wr_en  slot number and its new contents
//   act_x, act_y, act_en       active set seen by the hit logic
// Updates land in the shadow copy only, so the picture never changes
// mid-frame; the whole set switches over on frame_start.
module vga_sprite_bank #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 11,
  parameter int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  frame_start,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [IDX_W-1:0]                      wr_idx,
  input  logic [COORD_W-1:0]                    wr_x,
  input  logic [COORD_W-1:0]                    wr_y,
  input  logic                                  wr_en,
  output logic [NUM_SPRITES-1:0][COORD_W-1:0]   act_x,
  output logic [NUM_SPRITES-1:0][COORD_W-1:0]   act_y,
  output logic [NUM_SPRITES-1:0]                act_en
);

  logic [NUM_SPRITES-1:0][COORD_W-1:0] shd_x;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] shd_y;
  logic [NUM_SPRITES-1:0]              shd_en;

  // The commit cycle owns the shadow registers, so writers are held off
  // for exactly that cycle and retry on the next one.
  assign wr_ready = ~frame_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_x  <= '0;
      shd_y  <= '0;
      shd_en <= '0;
      act_x  <= '0;
      act_y  <= '0;
      act_en <= '0;
    end else if (frame_start) begin
      act_x  <= shd_x;
      act_y  <= shd_y;
      act_en <= shd_en;
    end else if (wr_valid && wr_ready) begin
      shd_x[wr_idx]  <= wr_x;
      shd_y[wr_idx]  <= wr_y;
      shd_en[wr_idx] <= wr_en;
    end
  end

endmodule

// File: rtl/vga_sprite_compositor.sv
// Two-stage per-pixel compositor: prioritised sprites over a tile map.
//   clk, reset              pixel clock, async active-high reset
//   row, col, pixel_valid   current pixel from the timing generator
//   frame_start             one-cycle pulse before the first visible pixel
//   wr_*                    sprite position update handshake
//   tile_row, tile_col      tile-map address (data returns next cycle)
//   tile_code               tile-map data
//   spr_sel, spr_x, spr_y   sprite ROM address (data returns next cycle)
//   spr_rgb                 sprite ROM data
//   red, green, blue        registered colour, two cycles after the pixel
//   out_valid               pixel_valid delayed to line up with the colour
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int     NUM_SPRITES = 4,
  parameter int     SPRITE_SIZE = 42,
  parameter int     BLOCK_WIDTH = 40,
  parameter int     TILE_COLS   = 17,
  parameter int     TILE_ROWS   = 12,
  parameter int     COORD_W     = vga_pkg::COORD_W,
  parameter rgb12_t TRANSP_KEY  = vga_pkg::TRANSPARENT,
  parameter int     IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_en,
  output logic [4:0]         tile_row,
  output logic [4:0]         tile_col,
  input  logic [7:0]         tile_code,
  output logic [IDX_W-1:0]   spr_sel,
  output logic [5:0]         spr_x,
  output logic [5:0]         spr_y,
  input  logic [11:0]        spr_rgb,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               out_valid
);

  localparam logic [COORD_W:0]   SIZE_M1 = (COORD_W+1)'(SPRITE_SIZE - 1);
  localparam logic [COORD_W-1:0] BW      = COORD_W'(BLOCK_WIDTH);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(TILE_ROWS - 1);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(TILE_COLS - 1);

  logic [NUM_SPRITES-1:0][COORD_W-1:0] act_x;
  logic [NUM_SPRITES-1:0][COORD_W-1:0] act_y;
  logic [NUM_SPRITES-1:0]              act_en;

  vga_sprite_bank #(
    .NUM_SPRITES (NUM_SPRITES),
    .COORD_W     (COORD_W),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_en       (wr_en),
    .act_x       (act_x),
    .act_y       (act_y),
    .act_en      (act_en)
  );

  // Tile address; pixels beyond the map reuse the last row/column.
  logic [COORD_W-1:0] row_tile;
  logic [COORD_W-1:0] col_tile;

  assign row_tile = row / BW;
  assign col_tile = col / BW;
  assign tile_row = (row_tile > ROW_MAX) ? 5'(ROW_MAX) : row_tile[4:0];
  assign tile_col = (col_tile > COL_MAX) ? 5'(COL_MAX) : col_tile[4:0];

  // Box test in one extra bit so a sprite near the top of the
  // coordinate range cannot wrap round and match small coordinates.
  logic [NUM_SPRITES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit[i] = act_en[i]
             && ({1'b0, col} >= {1'b0, act_x[i]})
             && ({1'b0, col} <= ({1'b0, act_x[i]} + SIZE_M1))
             && ({1'b0, row} >= {1'b0, act_y[i]})
             && ({1'b0, row} <= ({1'b0, act_y[i]} + SIZE_M1));
    end
  end

  // Lowest-numbered hit wins; scanning downwards lets it overwrite the rest.
  logic             win;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win     = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  assign dx      = col - act_x[win_idx];
  assign dy      = row - act_y[win_idx];
  assign spr_sel = win ? win_idx : '0;
  assign spr_x   = win ? dx[5:0] : '0;
  assign spr_y   = win ? dy[5:0] : '0;

  // Carry the per-pixel decisions alongside the memory read latency.
  logic s1_win;
  logic s1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_win   <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_win   <= win;
      s1_valid <= pixel_valid;
    end
  end

  // A transparent winner shows the background, never a lower-priority
  // sprite underneath it; blanked pixels are forced to black.
  rgb12_t pix;

  always_comb begin
    pix = tile_colour(tile_code);
    if (s1_win && (spr_rgb != TRANSP_KEY)) begin
      pix = spr_rgb;
    end
    if (!s1_valid) begin
      pix = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      out_valid <= 1'b0;
    end else begin
      red       <= pix[11:8];
      green     <= pix[7:4];
      blue      <= pix[3:0];
      out_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor with simple tile-map and
// sprite ROM models (both one cycle of read latency).
module tb_vga_sprite_compositor;
  import vga_pkg::*;

  logic        clk;
  logic        reset;
  logic [10:0] row;
  logic [10:0] col;
  logic        pixel_valid;
  logic        frame_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_idx;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic        wr_en;
  logic [4:0]  tile_row;
  logic [4:0]  tile_col;
  logic [7:0]  tile_code;
  logic [1:0]  spr_sel;
  logic [5:0]  spr_x;
  logic [5:0]  spr_y;
  logic [11:0] spr_rgb;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  vga_sprite_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_en       (wr_en),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .tile_code   (tile_code),
    .spr_sel     (spr_sel),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_rgb     (spr_rgb),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile map depends on column only; each sprite is one flat colour,
  // except an optional see-through pixel at local (20,20) of slot 0.
  logic [7:0]  tile_lut [32];
  logic [11:0] spr_color [4];
  logic        hole_en;

  always_ff @(posedge clk) begin
    tile_code <= tile_lut[tile_col];
    if (hole_en && spr_sel == 2'd0 && spr_x == 6'd20 && spr_y == 6'd20) begin
      spr_rgb <= TRANSPARENT;
    end else begin
      spr_rgb <= spr_color[spr_sel];
    end
  end

  typedef struct {
    int row;
    int col;
    int pv;
    int trow;
    int tcol;
    int sel;
    int sx;
    int sy;
    int rgb;
    int ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold one pixel, check the stage-0 addresses, then the colour two
  // edges later.
  task automatic apply_stimulus(input vec_t v, input string tag);
    row         = 11'(v.row);
    col         = 11'(v.col);
    pixel_valid = v.pv[0];
    #1;
    check_output({tag, ".tile_row"}, int'(tile_row), v.trow);
    check_output({tag, ".tile_col"}, int'(tile_col), v.tcol);
    check_output({tag, ".spr_sel"}, int'(spr_sel), v.sel);
    check_output({tag, ".spr_x"}, int'(spr_x), v.sx);
    check_output({tag, ".spr_y"}, int'(spr_y), v.sy);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output({tag, ".rgb"}, int'({red, green, blue}), v.rgb);
    check_output({tag, ".out_valid"}, int'(out_valid), v.ov);
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input int en);
    wr_valid = 1'b1;
    wr_idx   = 2'(idx);
    wr_x     = 11'(x);
    wr_y     = 11'(y);
    wr_en    = en[0];
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s_col [5];
    int s_pv [5];
    int s_rgb [5];

    for (int i = 0; i < 32; i++) tile_lut[i] = SKY;
    tile_lut[0] = BDR;
    tile_lut[1] = GND;
    tile_lut[2] = SKY;
    tile_lut[3] = TKN;
    tile_lut[4] = BLK;
    tile_lut[5] = CK1;
    tile_lut[6] = CK2;
    tile_lut[7] = 8'hFF;
    spr_color[0] = 12'hE00;
    spr_color[1] = 12'h0E0;
    spr_color[2] = 12'h00E;
    spr_color[3] = 12'h555;
    hole_en = 1'b0;

    reset       = 1'b1;
    row         = '0;
    col         = '0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    wr_idx      = '0;
    wr_x        = '0;
    wr_y        = '0;
    wr_en       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset.rgb", int'({red, green, blue}), 0);
    check_output("reset.out_valid", int'(out_valid), 0);
    check_output("reset.wr_ready", int'(wr_ready), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Mid-frame write must stay invisible until the next frame_start.
    write_slot(0, 100, 100, 1);
    apply_stimulus('{100, 100, 1, 2, 2, 0, 0, 0, 'h09F, 1}, "precommit");

    // Slot 1 is written twice; only the second position may survive.
    write_slot(1, 0, 0, 1);
    write_slot(1, 630, 300, 1);
    write_slot(2, 110, 110, 1);
    write_slot(3, 50, 400, 0);
    pulse_frame_start();

    vecs.push_back('{400,   10, 1, 10,  0, 0,  0,  0, 'h000, 1});
    vecs.push_back('{400,   50, 1, 10,  1, 0,  0,  0, 'h0F2, 1});
    vecs.push_back('{400,   90, 1, 10,  2, 0,  0,  0, 'h09F, 1});
    vecs.push_back('{400,  130, 1, 10,  3, 0,  0,  0, 'h09F, 1});
    vecs.push_back('{400,  170, 1, 10,  4, 0,  0,  0, 'h843, 1});
    vecs.push_back('{400,  210, 1, 10,  5, 0,  0,  0, 'hAA3, 1});
    vecs.push_back('{400,  250, 1, 10,  6, 0,  0,  0, 'h111, 1});
    vecs.push_back('{400,  290, 1, 10,  7, 0,  0,  0, 'h000, 1});
    vecs.push_back('{100,  100, 1,  2,  2, 0,  0,  0, 'hE00, 1});
    vecs.push_back('{100,  141, 1,  2,  3, 0, 41,  0, 'hE00, 1});
    vecs.push_back('{100,  142, 1,  2,  3, 0,  0,  0, 'h09F, 1});
    vecs.push_back('{141,  100, 1,  3,  2, 0,  0, 41, 'hE00, 1});
    vecs.push_back('{142,  100, 1,  3,  2, 0,  0,  0, 'h09F, 1});
    vecs.push_back('{120,  120, 1,  3,  3, 0, 20, 20, 'hE00, 1});
    vecs.push_back('{145,  145, 1,  3,  3, 2, 35, 35, 'h00E, 1});
    vecs.push_back('{300,  639, 1,  7, 15, 1,  9,  0, 'h0E0, 1});
    vecs.push_back('{341,  671, 1,  8, 16, 1, 41, 41, 'h0E0, 1});
    vecs.push_back('{600,  700, 1, 11, 16, 0,  0,  0, 'h09F, 1});
    vecs.push_back('{100,  100, 0,  2,  2, 0,  0,  0, 'h000, 0});
    vecs.push_back('{10,    10, 1,  0,  0, 0,  0,  0, 'h000, 1});
    vecs.push_back('{2047, 2047, 1, 11, 16, 0,  0,  0, 'h09F, 1});
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // See-through pixel of slot 0 over slot 2 must show the tile.
    hole_en = 1'b1;
    apply_stimulus('{120, 120, 1, 3, 3, 0, 20, 20, 'h09F, 1}, "transparent");
    hole_en = 1'b0;

    // Back-to-back pixels: each colour must appear exactly two edges later.
    s_col = '{10, 50, 90, 170, 210};
    s_pv  = '{1, 1, 0, 1, 1};
    s_rgb = '{'h000, 'h0F2, 'h000, 'h843, 'hAA3};
    row = 11'd400;
    for (int k = 0; k < 7; k++) begin
      if (k >= 2) begin
        check_output($sformatf("stream%0d.rgb", k - 2), int'({red, green, blue}), s_rgb[k - 2]);
        check_output($sformatf("stream%0d.out_valid", k - 2), int'(out_valid), s_pv[k - 2]);
      end
      if (k < 5) begin
        col         = 11'(s_col[k]);
        pixel_valid = s_pv[k][0];
      end else begin
        pixel_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    // Write held across frame_start: stalled that cycle, taken the next.
    wr_valid    = 1'b1;
    wr_idx      = 2'd3;
    wr_x        = 11'd300;
    wr_y        = 11'd400;
    wr_en       = 1'b1;
    frame_start = 1'b1;
    #1;
    check_output("stall.wr_ready_low", int'(wr_ready), 0);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    #1;
    check_output("stall.wr_ready_high", int'(wr_ready), 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    apply_stimulus('{410, 310, 1, 10, 7, 0, 0, 0, 'h000, 1}, "stall.precommit");
    pulse_frame_start();
    apply_stimulus('{410, 310, 1, 10, 7, 3, 10, 10, 'h555, 1}, "stall.committed");

    // Reset in the middle of a line clears outputs at once and all slots.
    #2;
    reset = 1'b1;
    #1;
    check_output("midreset.rgb", int'({red, green, blue}), 0);
    check_output("midreset.out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_output("midreset.wr_ready", int'(wr_ready), 1);
    apply_stimulus('{410, 310, 1, 10, 7, 0, 0, 0, 'h000, 1}, "midreset.active");
    pulse_frame_start();
    apply_stimulus('{145, 145, 1, 3, 3, 0, 0, 0, 'h09F, 1}, "midreset.shadow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
